// File: rtl/alu_multicycle.sv
// alu_multicycle: clocked ALU. Logic/arith/shift/compare ops finish in one
// cycle. Signed multiply (shift-add) and unsigned divide (restoring) take
// DATA_WIDTH iterations and report completion through a BUSY/DONE handshake.
module alu_multicycle #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    output logic [DATA_WIDTH-1:0] OUT,
    output logic [DATA_WIDTH-1:0] HI,
    output logic                  CO,
    output logic                  ZERO,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_MUL  = 4'h3,
        OP_SRL  = 4'h4,
        OP_SLL  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_NOR  = 4'h8,
        OP_SLT  = 4'h9,
        OP_DIVU = 4'hA
    } opcode_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    state_e        state;
    logic [CW-1:0] cnt;

    // Shared iteration datapath. MUL: acc_hi = partial high word, acc_lo =
    // multiplier shifting out / product low bits shifting in, operand =
    // multiplicand magnitude. DIV: acc_hi = remainder, acc_lo = dividend
    // shifting out / quotient bits shifting in, operand = divisor.
    logic [W-1:0] acc_hi;
    logic [W-1:0] acc_lo;
    logic [W-1:0] operand;
    logic         sign;

    logic [3:0] op;
    assign op = OPRN[3:0];

    // Upper opcode bits are deliberately ignored.
    logic [OPRN_WIDTH-1:0] oprn_unused;
    assign oprn_unused = OPRN;

    logic [W-1:0]   one_out;
    logic [W-1:0]   one_hi;
    logic           one_co;
    logic [W-1:0]   mag1;
    logic [W-1:0]   mag2;
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_hi_n;
    logic [W-1:0]   mul_lo_n;
    logic [2*W-1:0] mul_prod;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [W-1:0]   div_rem_n;
    logic [W-1:0]   div_quo_n;

    // Single-cycle result for every opcode that does not iterate.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred
        // for opcodes that do not assign it.
        one_out = '0;
        one_hi  = '0;
        one_co  = 1'b0;
        case (op)
            OP_ADD:  {one_co, one_out} = {1'b0, OP1} + {1'b0, OP2};
            OP_SUB: begin
                one_out = OP1 - OP2;
                one_co  = (OP1 >= OP2);  // no borrow
            end
            // Shift amounts >= W already yield zero with SV shift semantics.
            OP_SRL:  one_out = OP1 >> OP2;
            OP_SLL:  one_out = OP1 << OP2;
            OP_AND:  one_out = OP1 & OP2;
            OP_OR:   one_out = OP1 | OP2;
            OP_NOR:  one_out = ~(OP1 | OP2);
            // Signed compare, immune to the overflow of a subtract-and-test-sign.
            OP_SLT:  one_out = W'($signed(OP1) < $signed(OP2));
            OP_DIVU: begin  // only reached here for a zero divisor
                one_out = '1;
                one_hi  = OP1;
            end
            default: ;
        endcase
    end

    // Next-iteration values for the multiply and divide loops.
    always_comb begin
        mag1 = OP1[W-1] ? -OP1 : OP1;
        mag2 = OP2[W-1] ? -OP2 : OP2;

        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        mul_hi_n = mul_sum[W:1];
        mul_lo_n = {mul_sum[0], acc_lo[W-1:1]};
        mul_prod = sign ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};

        div_shift = {acc_hi, acc_lo[W-1]};
        div_ge    = (div_shift >= {1'b0, operand});
        div_diff  = W'(div_shift - {1'b0, operand});
        div_rem_n = div_ge ? div_diff : div_shift[W-1:0];
        div_quo_n = {acc_lo[W-2:0], div_ge};
    end

    // Iteration datapath: loaded on an accepted START, stepped while busy.
    // NOTE: these registers are left unreset; they are always loaded before
    // being read, and the FSM alone decides whether their contents matter.
    always_ff @(posedge CLK) begin
        if (state == IDLE) begin
            if (START) begin
                acc_hi  <= '0;
                acc_lo  <= (op == OP_MUL) ? mag2 : OP1;
                operand <= (op == OP_MUL) ? mag1 : OP2;
                sign    <= OP1[W-1] ^ OP2[W-1];
            end
        end else if (state == MUL) begin
            acc_hi <= mul_hi_n;
            acc_lo <= mul_lo_n;
        end else if (state == DIV) begin
            acc_hi <= div_rem_n;
            acc_lo <= div_quo_n;
        end
    end

    // Control FSM with registered result and handshake outputs.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments throughout so every register sees
        // the pre-edge value of every other register.
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            OUT   <= '0;
            HI    <= '0;
            CO    <= 1'b0;
            ZERO  <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        cnt <= '0;
                        if (op == OP_MUL) begin
                            state <= MUL;
                            BUSY  <= 1'b1;
                        end else if (op == OP_DIVU && OP2 != '0) begin
                            state <= DIV;
                            BUSY  <= 1'b1;
                        end else begin
                            OUT  <= one_out;
                            HI   <= one_hi;
                            CO   <= one_co;
                            ZERO <= (one_out == '0);
                            DONE <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        {HI, OUT} <= mul_prod;
                        ZERO      <= (mul_prod[W-1:0] == '0);
                        CO        <= 1'b0;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DIV: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        OUT   <= div_quo_n;
                        HI    <= div_rem_n;
                        ZERO  <= (div_quo_n == '0);
                        CO    <= 1'b0;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and randomized checks of alu_multicycle against
// an arithmetic reference model, including latency, handshake and reset abort.
module tb_alu_multicycle;
    localparam int W  = 32;
    localparam int OW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic [OW-1:0] OPRN = '0;
    logic [W-1:0]  OP1 = '0;
    logic [W-1:0]  OP2 = '0;
    logic [W-1:0]  OUT;
    logic [W-1:0]  HI;
    logic          CO;
    logic          ZERO;
    logic          BUSY;
    logic          DONE;

    int total = 0;
    int bad   = 0;

    alu_multicycle #(.DATA_WIDTH(W), .OPRN_WIDTH(OW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
        .OUT(OUT), .HI(HI), .CO(CO), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: results straight from the opcode definitions using wide arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] o, output logic [W-1:0] h,
                                  output logic c, output int lat);
        longint p;
        o = '0; h = '0; c = 1'b0; lat = 1;
        case (op)
            4'h1: {c, o} = {1'b0, a} + {1'b0, b};
            4'h2: begin o = a - b; c = (a >= b); end
            4'h3: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, o} = p;
                lat = W + 1;
            end
            4'h4: o = (b >= W) ? '0 : a >> b[5:0];
            4'h5: o = (b >= W) ? '0 : a << b[5:0];
            4'h6: o = a & b;
            4'h7: o = a | b;
            4'h8: o = ~(a | b);
            4'h9: o = ($signed(a) < $signed(b)) ? 1 : 0;
            4'hA: begin
                if (b == 0) begin o = '1; h = a; end
                else begin o = a / b; h = a % b; lat = W + 1; end
            end
            default: ;
        endcase
    endfunction

    // Issue one op, wait (bounded) for DONE, and check latency, BUSY and results.
    task automatic run_op(input string tag, input logic [OW-1:0] oprn,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        logic [W-1:0] eo, eh;
        logic ec;
        int lat, cycles;
        bit busy_bad;
        model(oprn[3:0], a, b, eo, eh, ec, lat);
        @(negedge CLK);
        START = 1'b1; OPRN = oprn; OP1 = a; OP2 = b;
        @(negedge CLK);
        START = 1'b0;
        cycles = 1;
        busy_bad = 1'b0;
        while (DONE !== 1'b1 && cycles < 100) begin
            if (BUSY !== 1'b1) busy_bad = 1'b1;
            if (noise && cycles >= 5 && cycles <= 20) begin
                START = 1'($urandom_range(0, 1));
                OPRN = OW'($urandom_range(0, 63));
                OP1 = $urandom;
                OP2 = $urandom;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            cycles++;
        end
        START = 1'b0;
        check({tag, ".lat"}, cycles, lat);
        check({tag, ".busy_during"}, busy_bad, 0);
        check({tag, ".busy_at_done"}, BUSY, 0);
        check({tag, ".out"}, OUT, eo);
        check({tag, ".hi"}, HI, eh);
        check({tag, ".co"}, CO, ec);
        check({tag, ".zero"}, ZERO, (eo == 0));
        @(negedge CLK);
        check({tag, ".done_pulse"}, DONE, 0);
        check({tag, ".hold"}, OUT, eo);
    endtask

    initial begin
        logic [W-1:0] ra, rb, eo, eh;
        logic ec;
        int lat;
        bit done_seen;
        logic [3:0] b2b_op [3];
        logic [W-1:0] b2b_a [3];
        logic [W-1:0] b2b_b [3];

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst.out", OUT, 0);
        check("rst.hi", HI, 0);
        check("rst.co", CO, 0);
        check("rst.zero", ZERO, 1);
        check("rst.busy", BUSY, 0);
        check("rst.done", DONE, 0);
        RST = 1'b1;

        // Directed cases
        run_op("add15_3", 6'h01, 15, 3, 0);
        run_op("add_wrap", 6'h01, 32'hFFFF_FFFF, 1, 0);
        run_op("sub_borrow", 6'h02, 3, 15, 0);
        run_op("sub_eq", 6'h02, 7, 7, 0);
        run_op("mul_neg_noise", 6'h03, 32'hFFFF_FFFF, 32'hF, 1);
        run_op("mul15_5", 6'h03, 15, 5, 0);
        run_op("mul_minneg", 6'h03, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div100_7", 6'h0A, 100, 7, 0);
        run_op("div9_0", 6'h0A, 9, 0, 0);
        run_op("div_max", 6'h0A, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_op("sll15_5", 6'h05, 15, 5, 0);
        run_op("srl15_5", 6'h04, 15, 5, 0);
        run_op("sll15_32", 6'h05, 15, 32, 0);
        run_op("slt5_15", 6'h09, 5, 15, 0);
        run_op("slt_minneg", 6'h09, 32'h8000_0000, 1, 0);
        run_op("slt_maxpos", 6'h09, 32'h7FFF_FFFF, 32'h8000_0000, 0);
        run_op("undef_op", 6'h3F, 32'h1234, 32'h5678, 0);

        // Back-to-back and/or/nor, one DONE per cycle
        b2b_op = '{4'h6, 4'h7, 4'h8};
        for (int i = 0; i < 3; i++) begin
            b2b_a[i] = $urandom;
            b2b_b[i] = $urandom;
        end
        @(negedge CLK);
        START = 1'b1; OPRN = {2'b00, b2b_op[0]}; OP1 = b2b_a[0]; OP2 = b2b_b[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            model(b2b_op[i], b2b_a[i], b2b_b[i], eo, eh, ec, lat);
            check($sformatf("b2b%0d.done", i), DONE, 1);
            check($sformatf("b2b%0d.out", i), OUT, eo);
            if (i < 2) begin
                OPRN = {2'b00, b2b_op[i+1]}; OP1 = b2b_a[i+1]; OP2 = b2b_b[i+1];
            end else begin
                START = 1'b0;
            end
        end
        @(negedge CLK);
        check("b2b.done_drop", DONE, 0);

        // Reset in the middle of a divide aborts it
        START = 1'b1; OPRN = 6'h0A; OP1 = 100; OP2 = 7;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        check("abort.busy_before", BUSY, 1);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("abort.busy", BUSY, 0);
        check("abort.out", OUT, 0);
        check("abort.hi", HI, 0);
        check("abort.zero", ZERO, 1);
        check("abort.done", DONE, 0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (DONE === 1'b1) done_seen = 1'b1;
        end
        check("abort.no_done", done_seen, 0);
        run_op("add2_2", 6'h01, 2, 2, 0);

        // Randomized ops
        for (int n = 0; n < 60; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom_range(0, 40);
                1: rb = (rop == 4'hA) ? 0 : $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) ra = $urandom_range(0, 3);
            run_op($sformatf("rnd%0d_op%0h", n, rop), {2'($urandom_range(0, 3)), rop}, ra, rb,
                   bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
